// File: rtl/per_bridge_pkg.sv
// Shared definitions for the CPU-to-peripheral bridge: access sizes, FSM states,
// slot decode positions and the access legality check.
package per_bridge_pkg;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_STROBE = 2'd1,
    ST_WAIT   = 2'd2,
    ST_DONE   = 2'd3
  } state_e;

  localparam logic [1:0] SIZE_BYTE = 2'd0;
  localparam logic [1:0] SIZE_HALF = 2'd1;
  localparam logic [1:0] SIZE_WORD = 2'd2;
  localparam logic [1:0] SIZE_ILL  = 2'd3;

  localparam int PER_SLOT_LSB  = 16;
  localparam int PER_SLOT_BITS = 4;

  // Any single failing condition makes the access illegal.
  function automatic logic access_legal(input logic [31:0] addr,
                                        input logic [1:0]  size,
                                        input logic        rd,
                                        input logic        wr,
                                        input logic [11:0] base_hi,
                                        input logic [4:0]  nslots);
    logic ok;
    ok = 1'b1;
    if (addr[31:20] != base_hi) ok = 1'b0;
    if ({1'b0, addr[PER_SLOT_LSB +: PER_SLOT_BITS]} >= nslots) ok = 1'b0;
    case (size)
      SIZE_HALF: if (addr[0]) ok = 1'b0;
      SIZE_WORD: if (addr[1:0] != 2'b00) ok = 1'b0;
      SIZE_ILL:  ok = 1'b0;
      default:   ok = ok;
    endcase
    if (rd && wr) ok = 1'b0;
    return ok;
  endfunction

endpackage

// File: rtl/per_bridge_if.sv
// CPU-side and peripheral-side bus bundles of the bridge.
interface per_bridge_cpu_if;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [1:0]  size;
  logic        rd;
  logic        wr;
  logic [31:0] rdata;
  logic        ready;
  logic        error;

  modport master (output addr, wdata, size, rd, wr, input rdata, ready, error);
  modport slave  (input addr, wdata, size, rd, wr, output rdata, ready, error);
endinterface

interface per_bridge_per_if #(parameter int NSLOTS = 4);
  logic [15:0]          addr;
  logic [31:0]          wdata;
  logic [1:0]           size;
  logic [NSLOTS-1:0]    rd;
  logic [NSLOTS-1:0]    wr;
  logic [NSLOTS*32-1:0] rdata;

  modport master (output addr, wdata, size, rd, wr, input rdata);
  modport slave  (input addr, wdata, size, rd, wr, output rdata);
endinterface

// File: rtl/per_rdata_align.sv
// Selects one slot's read data and right-aligns/zero-extends it to the access size.
module per_rdata_align
  import per_bridge_pkg::*;
#(
  parameter int NSLOTS = 4
) (
  input  logic [NSLOTS*32-1:0] per_rdata_i,
  input  logic [3:0]           slot_i,
  input  logic [1:0]           off_i,
  input  logic [1:0]           size_i,
  output logic [31:0]          rdata_o
);

  logic [31:0] sel_s;
  logic [31:0] shifted_s;

  always_comb begin
    sel_s = 32'h0000_0000;
    for (int i = 0; i < NSLOTS; i++) begin
      sel_s = (slot_i == 4'(i)) ? per_rdata_i[i*32 +: 32] : sel_s;
    end
    shifted_s = sel_s >> {off_i, 3'b000};
    case (size_i)
      SIZE_BYTE: rdata_o = {24'h00_0000, shifted_s[7:0]};
      SIZE_HALF: rdata_o = {16'h0000, shifted_s[15:0]};
      default:   rdata_o = shifted_s;
    endcase
  end

endmodule

// File: rtl/per_bridge.sv
// CPU data-bus to peripheral-bus bridge: one access in flight, one-cycle slot
// strobe, fixed 3-cycle latency for legal accesses, 1-cycle error completion.
module per_bridge
  import per_bridge_pkg::*;
#(
  parameter int          NSLOTS    = 4,
  parameter logic [31:0] BASE_ADDR = 32'h8000_0000
) (
  input  logic             clk_i,
  input  logic             reset_n_i,
  per_bridge_cpu_if.slave  cpu_io,
  per_bridge_per_if.master per_io
);

  state_e state_q, state_d;

  logic [15:0]       per_addr_q, per_addr_d;
  logic [31:0]       per_wdata_q, per_wdata_d;
  logic [1:0]        per_size_q, per_size_d;
  logic [NSLOTS-1:0] per_rd_q, per_rd_d;
  logic [NSLOTS-1:0] per_wr_q, per_wr_d;
  logic [31:0]       rdata_q, rdata_d;
  logic              ready_q, ready_d;
  logic              error_q, error_d;
  logic              is_rd_q, is_rd_d;
  logic [3:0]        slot_q, slot_d;
  logic [1:0]        off_q, off_d;

  logic        req_s;
  logic        legal_s;
  logic [31:0] aligned_s;

  assign req_s   = cpu_io.rd | cpu_io.wr;
  assign legal_s = access_legal(cpu_io.addr, cpu_io.size, cpu_io.rd, cpu_io.wr,
                                BASE_ADDR[31:20], 5'(NSLOTS));

  per_rdata_align #(.NSLOTS(NSLOTS)) u_align (
    .per_rdata_i (per_io.rdata),
    .slot_i      (slot_q),
    .off_i       (off_q),
    .size_i      (per_size_q),
    .rdata_o     (aligned_s)
  );

  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) state_q <= ST_IDLE;
    else            state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s) state_d = legal_s ? ST_STROBE : ST_DONE;
        else       state_d = ST_IDLE;
      end
      ST_STROBE: state_d = ST_WAIT;
      ST_WAIT:   state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Next values of every registered output; strobes and ready default to low.
  always_comb begin
    per_addr_d  = per_addr_q;
    per_wdata_d = per_wdata_q;
    per_size_d  = per_size_q;
    per_rd_d    = '0;
    per_wr_d    = '0;
    rdata_d     = rdata_q;
    ready_d     = 1'b0;
    error_d     = 1'b0;
    is_rd_d     = is_rd_q;
    slot_d      = slot_q;
    off_d       = off_q;
    case (state_q)
      ST_IDLE: begin
        if (req_s && legal_s) begin
          per_addr_d  = cpu_io.addr[15:0];
          per_wdata_d = cpu_io.wdata;
          per_size_d  = cpu_io.size;
          slot_d      = cpu_io.addr[PER_SLOT_LSB +: PER_SLOT_BITS];
          off_d       = cpu_io.addr[1:0];
          is_rd_d     = cpu_io.rd;
          rdata_d     = 32'h0000_0000;
          per_rd_d    = cpu_io.rd ? (NSLOTS'(1) << slot_d) : '0;
          per_wr_d    = cpu_io.wr ? (NSLOTS'(1) << slot_d) : '0;
        end else if (req_s) begin
          rdata_d = 32'h0000_0000;
          ready_d = 1'b1;
          error_d = 1'b1;
        end else begin
          rdata_d = rdata_q;
        end
      end
      ST_WAIT: begin
        rdata_d = is_rd_q ? aligned_s : 32'h0000_0000;
        ready_d = 1'b1;
      end
      default: begin
        ready_d = 1'b0;
      end
    endcase
  end

  // Output and access-context registers.
  always_ff @(posedge clk_i or negedge reset_n_i) begin
    if (!reset_n_i) begin
      per_addr_q  <= 16'h0000;
      per_wdata_q <= 32'h0000_0000;
      per_size_q  <= 2'b00;
      per_rd_q    <= '0;
      per_wr_q    <= '0;
      rdata_q     <= 32'h0000_0000;
      ready_q     <= 1'b0;
      error_q     <= 1'b0;
      is_rd_q     <= 1'b0;
      slot_q      <= 4'h0;
      off_q       <= 2'b00;
    end else begin
      per_addr_q  <= per_addr_d;
      per_wdata_q <= per_wdata_d;
      per_size_q  <= per_size_d;
      per_rd_q    <= per_rd_d;
      per_wr_q    <= per_wr_d;
      rdata_q     <= rdata_d;
      ready_q     <= ready_d;
      error_q     <= error_d;
      is_rd_q     <= is_rd_d;
      slot_q      <= slot_d;
      off_q       <= off_d;
    end
  end

  assign per_io.addr  = per_addr_q;
  assign per_io.wdata = per_wdata_q;
  assign per_io.size  = per_size_q;
  assign per_io.rd    = per_rd_q;
  assign per_io.wr    = per_wr_q;
  assign cpu_io.rdata = rdata_q;
  assign cpu_io.ready = ready_q;
  assign cpu_io.error = error_q;

endmodule
